// File: rtl/instr_prefetch_buf_pkg.sv
// instr_prefetch_pkg: shared types and constants for the instruction prefetch buffer
package instr_prefetch_pkg;
  localparam int RAM_RD_LATENCY = 1;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_e;
endpackage

// File: rtl/instr_prefetch_buf_if.sv
// instr_prefetch_buf_if: core fetch channels and RAM read port of the prefetch buffer
interface instr_prefetch_buf_if #(parameter int ADDR_WIDTH = 17);
  import instr_prefetch_pkg::*;
  logic req_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic gnt_o;
  logic rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic rready_i;
  logic flush_i;
  logic ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_rdata_i;
  logic ram_we_o;
  logic [3:0] ram_be_o;
  modport slave (
    input req_i, addr_i, rready_i, flush_i, ram_rdata_i,
    output gnt_o, rvalid_o, rdata_o, ram_en_o, ram_addr_o, ram_we_o, ram_be_o
  );
  modport master (
    output req_i, addr_i, rready_i, flush_i, ram_rdata_i,
    input gnt_o, rvalid_o, rdata_o, ram_en_o, ram_addr_o, ram_we_o, ram_be_o
  );
endinterface

// File: rtl/instr_prefetch_buf_fifo.sv
// prefetch_fifo: response word FIFO with clear; full/empty come from the occupancy count
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [CW-1:0]     cnt_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wptr_d = clr_i ? '0 : wptr_q + PW'(push_i);
    rptr_d = clr_i ? '0 : rptr_q + PW'(pop_i);
    cnt_d  = clr_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rptr_q];
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/instr_prefetch_buf.sv
// instr_prefetch_buf: credit-limited fetch bridge to the 1-cycle instruction RAM/ROM with a response FIFO
// Optional INSTR_PREFETCH_BYPASS_EN forwards the returning word straight to the core when the FIFO is empty.
module instr_prefetch_buf
  import instr_prefetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  instr_prefetch_buf_if.slave bus
);
  state_e state_q, state_d;
  logic gnt, push, pop, byp, inflight, empty, full;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0] cnt;
  assign inflight = state_q != IDLE;
  // Credit counts the outstanding read so a returning word always has a slot.
  assign gnt = bus.req_i & ~bus.flush_i & ~rst & ((cnt + CNT_W'(inflight)) < CNT_W'(DEPTH));
`ifdef INSTR_PREFETCH_BYPASS_EN
  assign byp = (state_q == BUSY) & empty & bus.rready_i & ~bus.flush_i;
`else
  assign byp = 1'b0;
`endif
  assign pop  = ~empty & bus.rready_i;
  assign push = (state_q == BUSY) & ~bus.flush_i & ~byp & (~full | pop);
  prefetch_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.ram_rdata_i),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .cnt_o   (cnt)
  );
  always_comb begin
    state_d = state_q;
    state_d = (state_q == BUSY && bus.flush_i) ? DISCARD : gnt ? BUSY : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  assign bus.gnt_o      = gnt;
  assign bus.ram_en_o   = gnt;
  assign bus.ram_addr_o = gnt ? bus.addr_i : ADDR_WIDTH'(0);
  assign bus.ram_we_o   = 1'b0;
  assign bus.ram_be_o   = 4'hF;
  assign bus.rvalid_o   = ~empty | byp;
  assign bus.rdata_o    = ~empty ? head : byp ? bus.ram_rdata_i : '0;
endmodule
